tt_um_ring_johnson_counter: RTL



---
 rtl/tt_um_ring_johnson_counter.sv | 75 +++++++
 1 files changed

// File: rtl/tt_um_ring_johnson_counter.sv
// Parametrised ring / Johnson rotating counter with direction, load,
// illegal-state detection (optional self-correction) and a wrap pulse.
module tt_um_ring_johnson_counter #(
    parameter int WIDTH       = 8,
    parameter bit AUTOCORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    logic             mode_q;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-2:0] trans;
    logic             fb_up;
    logic             fb_dn;
    logic             legal;

    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        return m ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Johnson mode inverts the bit wrapping around the end of the register.
    always_comb begin
        seed_cur = seed_of(mode_q);
        fb_up    = q[WIDTH-1] ^ mode_q;
        fb_dn    = q[0] ^ mode_q;
        step_q   = dir ? {fb_dn, q[WIDTH-1:1]} : {q[WIDTH-2:0], fb_up};
    end

    // Ring: exactly one bit set. Johnson: at most one adjacent-bit transition.
    always_comb begin
        trans = q[WIDTH-1:1] ^ q[WIDTH-2:0];
        if (mode_q)
            legal = (trans & (trans - (WIDTH-1)'(1))) == '0;
        else
            legal = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= seed_of(mode);
            mode_q <= mode;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (mode != mode_q) begin
                q      <= seed_of(mode);
                mode_q <= mode;
            end else if (load) begin
                q <= load_val;
            end else if (en) begin
                if (!legal) err <= 1'b1;
                // Correction lands on the seed silently; only true steps report wrap.
                if (!legal && AUTOCORRECT) begin
                    q <= seed_cur;
                end else begin
                    q    <= step_q;
                    wrap <= (step_q == seed_cur);
                end
            end
        end
    end

endmodule
